// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage.
//
// Holds the PC, issues sequential reads to a synchronous instruction SRAM
// (data returns one cycle after the request), queues returned words in a
// small circular buffer and hands them to decode over a valid/allow-in
// handshake. A redirect from decode flushes the buffer, discards any read in
// flight and restarts fetch at the target.
//
// Handshake: an entry transfers in a cycle where fs_to_ds_valid and
// ds_allow_in are both 1; fs_to_ds_valid never depends on ds_allow_in, and the
// head fields stay stable while valid is held without a transfer.
//
// Parameters:
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  instruction buffer entries (2 or 4)
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   inst_sram_en/we/addr/wdata read request to the inst SRAM (we/wdata tied 0)
//   inst_sram_rdata            read data, valid one cycle after en
//   br_valid, br_target        redirect request and target from decode
//   ds_allow_in                decode can accept an instruction
//   fs_to_ds_valid/pc/inst     buffer head presented to decode
//   fs_to_ds_adef              head entry carries a fetch-address exception
//
// Build option:
//   IF_ADEF_CHECK_EN  when defined, a misaligned redirect target produces one
//                     adef entry and halts fetch until the next redirect;
//                     otherwise the target's low two bits are dropped.
// ---------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        ds_allow_in,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic        fs_to_ds_adef
);
    localparam int            PW      = $clog2(BUF_DEPTH);
    localparam int            CW      = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   issued_pc_q;
    logic          req_pend_q;
    logic          kill_q, kill_d;
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   buf_pc_q   [BUF_DEPTH];
    logic [31:0]   buf_inst_q [BUF_DEPTH];

    logic          halted;
    logic          pop;
    logic          push;
    logic [31:0]   push_pc, push_inst;
    logic [31:0]   redirect_pc;
    logic [CW:0]   credit;
    logic          head_ok;

`ifdef IF_ADEF_CHECK_EN
    logic halted_q, halted_d;
    logic adef_pend_q, adef_pend_d;
    logic misaligned;
    logic push_adef;
    logic buf_adef_q [BUF_DEPTH];

    assign misaligned  = (br_target[1:0] != 2'b00);
    assign redirect_pc = br_target;
    assign halted      = halted_q;
`else
    logic unused_br_lsb;

    assign unused_br_lsb = ^br_target[1:0];
    assign redirect_pc   = {br_target[31:2], 2'b00};
    assign halted        = 1'b0;
`endif

    assign head_ok        = (count_q != '0);
    assign fs_to_ds_valid = head_ok & ~br_valid;
    assign pop            = fs_to_ds_valid & ds_allow_in;

    // Occupancy counting the in-flight read and this cycle's pop: issuing only
    // while it is below the depth guarantees every return finds a free slot.
    assign credit = {1'b0, count_q} + {{CW{1'b0}}, req_pend_q} - {{CW{1'b0}}, pop};

    assign inst_sram_en    = ~reset & ~br_valid & ~halted & (credit < DEPTH_W);
    assign inst_sram_we    = 1'b0;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_pc   = head_ok ? buf_pc_q[head_q]   : 32'h0;
    assign fs_to_ds_inst = head_ok ? buf_inst_q[head_q] : 32'h0;
`ifdef IF_ADEF_CHECK_EN
    assign fs_to_ds_adef = head_ok & buf_adef_q[head_q];
`else
    assign fs_to_ds_adef = 1'b0;
`endif

    // Push source: the SRAM return, or (with adef checking) the synthetic
    // exception entry in the cycle after a misaligned redirect.
    always_comb begin
        push      = 1'b0;
        push_pc   = issued_pc_q;
        push_inst = inst_sram_rdata;
`ifdef IF_ADEF_CHECK_EN
        push_adef = 1'b0;
`endif
        if (!br_valid) begin
            if (req_pend_q && !kill_q) begin
                push = 1'b1;
`ifdef IF_ADEF_CHECK_EN
            end else if (adef_pend_q) begin
                push      = 1'b1;
                push_pc   = pc_q;
                push_inst = 32'h0;
                push_adef = 1'b1;
`endif
            end
        end
    end

    always_comb begin
        pc_d    = pc_q;
        kill_d  = 1'b0;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (br_valid) begin
            pc_d    = redirect_pc;
            kill_d  = req_pend_q;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (inst_sram_en) pc_d = pc_q + 32'd4;
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            issued_pc_q <= RESET_PC;
            req_pend_q  <= 1'b0;
            kill_q      <= 1'b0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pend_q <= inst_sram_en;
            kill_q     <= kill_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            if (inst_sram_en) issued_pc_q <= pc_q;
        end
    end

    // Buffer storage needs no reset: empty entries are masked at the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_q[tail_q]   <= push_pc;
            buf_inst_q[tail_q] <= push_inst;
`ifdef IF_ADEF_CHECK_EN
            buf_adef_q[tail_q] <= push_adef;
`endif
        end
    end

`ifdef IF_ADEF_CHECK_EN
    always_comb begin
        halted_d    = halted_q;
        adef_pend_d = 1'b0;
        if (br_valid) begin
            halted_d    = misaligned;
            adef_pend_d = misaligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q    <= 1'b0;
            adef_pend_q <= 1'b0;
        end else begin
            halted_q    <= halted_d;
            adef_pend_q <= adef_pend_d;
        end
    end
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the LoongArch CPU. It holds the PC and issues sequential reads to the synchronous inst SRAM. Returned instructions are queued in a small buffer and handed to the decode stage over a valid/allow-in handshake. A decode-stage redirect (branch/jump) flushes everything in flight and restarts fetch at the target.

## Interface
- `RESET_PC`, default 32'h1c00_0000: first fetch address after reset.
- `BUF_DEPTH`, default 2: instruction buffer entries; legal values are 2 and 4.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `inst_sram_en` in→out 1: read request this cycle.
- `inst_sram_we` out 1: tied 0.
- `inst_sram_addr` out 32: read address, equal to the current PC register.
- `inst_sram_wdata` out 32: tied 0.
- `inst_sram_rdata` in 32: read data, valid exactly one cycle after an `inst_sram_en`=1 cycle.
- `br_valid` in 1: redirect request from decode.
- `br_target` in 32: redirect address, sampled when `br_valid`=1.
- `ds_allow_in` in 1: decode can accept an instruction this cycle.
- `fs_to_ds_valid` out 1: buffer head is presented to decode.
- `fs_to_ds_pc` out 32: PC of the head entry.
- `fs_to_ds_inst` out 32: instruction word of the head entry.
- `fs_to_ds_adef` out 1: head entry carries a fetch-address exception (see Configuration).

## Operation
- **State**
  - `pc` register.
  - `req_pend` flag: a read issued last cycle whose data arrives this cycle.
  - `kill` flag: discard the pending data.
  - Circular buffer of {pc, inst, adef} entries, with a head pointer, a tail pointer and `count` (0..BUF_DEPTH).
- **Pop**
  - `pop` = `fs_to_ds_valid` & `ds_allow_in`.
  - `fs_to_ds_valid` = (`count`≠0) & ~`br_valid`. A redirect cycle never transfers.
- **Issue**
  - `inst_sram_en` = ~`br_valid` & ~`halted` & (`count` + `req_pend` − `pop` < BUF_DEPTH).
  - This credit rule guarantees returned data always has a free slot; the buffer never overflows.
  - On issue: `pc` ← `pc`+4 (mod 2^32, wraps from 32'hffff_fffc to 0); `req_pend` ← 1; the issued PC is held with the request.
- **Return**
  - When `req_pend`=1 and `kill`=0, {issued pc, `inst_sram_rdata`, 0} is written at the tail.
  - Push and pop may occur in the same cycle; `count` is then unchanged.
- **Redirect** (`br_valid`=1), which has priority over everything:
  - `count` ← 0, pointers ← 0.
  - `kill` ← `req_pend` (discards data returning next cycle).
  - `pc` ← `br_target`; `halted` ← 0.
  - No issue and no pop that cycle.
- `kill` clears after the discarded return cycle.
- `br_valid` with an empty buffer and no pending request only reloads `pc`.

## Timing
- **Reset values**
  - `pc`=RESET_PC; `count`=0; `req_pend`=0; `kill`=0; `halted`=0.
  - `inst_sram_en`=0 while `reset`=1; `inst_sram_addr`=RESET_PC.
  - `fs_to_ds_valid`=0; `fs_to_ds_pc`=0; `fs_to_ds_inst`=0; `fs_to_ds_adef`=0.
  - Empty-buffer head fields read as 0.
- **Latency and throughput**
  - Issue in cycle N → data captured at the end of N+1 → `fs_to_ds_valid`=1 in N+2.
  - First issue is in the first cycle after `reset` falls.
  - Sustained throughput is 1 instruction/cycle with `ds_allow_in` held 1.
- **Redirect penalty:** `br_valid` in cycle N → target issued in N+1 → target instruction valid in N+3.
- **Stall:** with `ds_allow_in`=0, issue stops once `count`+`req_pend`=BUF_DEPTH. The head entry and outputs stay stable until popped.
- **Reset mid-operation:** any pending SRAM data after `reset` falls is ignored, because `req_pend`=0.

## Configuration
- **`IF_ADEF_CHECK_EN` defined**
  - A redirect with `br_target[1:0]`≠0 loads `pc` and sets `halted`.
  - The next cycle pushes one entry {`br_target`, 32'h0, adef=1} without an SRAM read.
  - Fetch then stays idle (`inst_sram_en`=0) until the next `br_valid`.
- **`IF_ADEF_CHECK_EN` not defined**
  - `br_target[1:0]` is ignored and the PC is loaded as {`br_target[31:2]`, 2'b00}.
  - `fs_to_ds_adef` is tied 0 and `halted` is never set.

## Test plan
- **Reset release, `ds_allow_in`=1:** SRAM returns addr+0x100.
  - PCs 1c000000, 1c000004, 1c000008 are presented on consecutive cycles from cycle 2.
  - `inst` equals the model data.
- **Backpressure:** `ds_allow_in`=0 for 10 cycles after first valid.
  - `inst_sram_en` drops after BUF_DEPTH outstanding.
  - Head stays pc 1c000000.
  - On release, the order continues with no gap and no duplicate.
- **Redirect with pending request:** `br_valid` with target 1c000100 while `count`=1 and `req_pend`=1.
  - No transfer that cycle.
  - The stale return is discarded.
  - Next valid is pc 1c000100, three cycles later.
- **Wrap-around:** redirect to ffff_fffc.
  - Presented PCs are fffffffc then 00000000.
- **Simultaneous redirect and allow-in with a full buffer:** `fs_to_ds_valid` is 0 that cycle and the buffer empties.
- **Misaligned target:** redirect to 1c000102.
  - With `IF_ADEF_CHECK_EN`: one entry {1c000102, 0, adef=1}, then idle until the next redirect.
  - Without it: fetch resumes at 1c000100 and adef stays 0.
